// File: rtl/apb_mem_slave_p.sv
// APB4 scratch-RAM slave with configurable width, window, wait states and
// byte strobes. Out-of-window or misaligned accesses complete with PSLVERR.
// Protocol violations pulse prot_err for one cycle.
// Ports: PCLK/RSTN clock and async active-low reset; PSEL, PENABLE, PWRITE,
// PADDR, PWDATA, PSTRB from the master; PREADY, PRDATA, PSLVERR, prot_err out.
module apb_mem_slave_p #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned LOW_ADDR    = 'h010,
  parameter int unsigned HIGH_ADDR   = 'h3FC,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    RSTN,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR,
  output logic                    prot_err
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned ALSB  = $clog2(NB);
  localparam int unsigned IW    = ADDR_WIDTH - ALSB;
  localparam int unsigned DEPTH = 2 ** IW;

  localparam logic [ADDR_WIDTH-1:0] LO_A  = ADDR_WIDTH'(LOW_ADDR);
  localparam logic [ADDR_WIDTH-1:0] HI_A  = ADDR_WIDTH'(HIGH_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ADDR_WIDTH'((1 << ALSB) - 1);
  localparam logic [3:0]            WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    prot_q, prot_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic addr_err, setup, ready, complete, mem_we;

  // Misalignment mask is all-zero for byte-wide buses, so no lane check then.
  assign addr_err = (PADDR < LO_A) || (PADDR > HI_A) || (|(PADDR & AMASK));
  assign setup    = PSEL && !PENABLE;
  assign ready    = (state_q == ACCESS) && (cnt_q == WS);
  assign complete = ready && PSEL && PENABLE;
  assign mem_we   = complete && write_q && !err_q;

  always_ff @(posedge PCLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = ACCESS;
      ACCESS: begin
        if (!PSEL)         state_d = IDLE;
        else if (complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    PREADY   = ready;
    PSLVERR  = ready && err_q;
    PRDATA   = prdata_q;
    prot_err = prot_q;

    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    prot_d   = 1'b0;

    // A setup seen in ACCESS is both a violation and a fresh capture.
    if (setup) begin
      addr_d  = PADDR;
      write_d = PWRITE;
      err_d   = addr_err;
      cnt_d   = '0;
      if (!PWRITE) prdata_d = addr_err ? '0 : mem_q[PADDR[ADDR_WIDTH-1:ALSB]];
    end else if (state_q == ACCESS && cnt_q < WS) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (state_d == IDLE) cnt_d = '0;

    if (state_q == IDLE) begin
      prot_d = PENABLE;
    end else if (PSEL) begin
      prot_d = !PENABLE || (PADDR != addr_q) || (PWRITE != write_q);
    end
  end

  always_ff @(posedge PCLK or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      prdata_q <= '0;
      prot_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      prot_q   <= prot_d;
    end
  end

  always_ff @(posedge PCLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (PSTRB[b]) mem_q[addr_q[ADDR_WIDTH-1:ALSB]][8*b +: 8] <= PWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_p.sv
module tb_apb_mem_slave_p;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    bit          rd;
    int          len;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        psel, penable, pwrite;
  logic [9:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  bit          dut_b;

  logic        psel_a, penable_a, psel_b, penable_b;
  logic        ready_a, slverr_a, prot_a, ready_b, slverr_b, prot_b;
  logic [31:0] rdata_a, rdata_b;
  logic        cur_ready, cur_slverr, cur_prot;
  logic [31:0] cur_rdata;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   setup_cyc = 0;
  int   prot_seen = 0;

  assign psel_a     = psel & ~dut_b;
  assign penable_a  = penable & ~dut_b;
  assign psel_b     = psel & dut_b;
  assign penable_b  = penable & dut_b;
  assign cur_ready  = dut_b ? ready_b  : ready_a;
  assign cur_slverr = dut_b ? slverr_b : slverr_a;
  assign cur_prot   = dut_b ? prot_b   : prot_a;
  assign cur_rdata  = dut_b ? rdata_b  : rdata_a;

  apb_mem_slave_p #(.WAIT_STATES(1)) u_a (
    .PCLK(clk), .RSTN(rstn), .PSEL(psel_a), .PENABLE(penable_a), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(ready_a),
    .PRDATA(rdata_a), .PSLVERR(slverr_a), .prot_err(prot_a)
  );

  apb_mem_slave_p #(.WAIT_STATES(0)) u_b (
    .PCLK(clk), .RSTN(rstn), .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(ready_b),
    .PRDATA(rdata_b), .PSLVERR(slverr_b), .prot_err(prot_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rstn === 1'b1 && cur_prot === 1'b1) prot_seen++;
    if (rstn === 1'b1 && cur_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_pready", 32'(cur_ready), 32'd0);
      end else begin
        e = q.pop_front();
        chk("pslverr", 32'(cur_slverr), 32'(e.err));
        if (e.rd) chk("prdata", cur_rdata, e.rdata);
        chk("latency", 32'(cyc - setup_cyc + 1), 32'(e.len));
      end
    end
  end

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: plain; 1: PADDR disturbed in first access cycle; 2: preceded by
  // a read setup of 'h030 that gets replaced by a second setup.
  task automatic xfer(input bit wr, input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] er, input bit ee,
                      input int mode);
    exp_t e;
    int   k;
    e.rdata = er; e.err = ee; e.rd = !wr; e.len = dut_b ? 2 : 3;
    if (mode == 2) begin
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h030;
      @(posedge clk); #1;
    end
    q.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    setup_cyc = cyc;
    @(posedge clk); #1;
    penable = 1'b1;
    if (mode == 1) begin
      paddr = a ^ 10'h030;
      @(posedge clk); #1;
      paddr = a;
    end
    k = 0;
    @(negedge clk);
    while (cur_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      chk("ready_timeout", 32'(cur_ready), 32'd1);
      void'(q.pop_front());
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; dut_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready",   32'(ready_a),  32'd0);
    chk("rst_prdata",   rdata_a,       32'd0);
    chk("rst_pslverr",  32'(slverr_a), 32'd0);
    chk("rst_prot",     32'(prot_a),   32'd0);
    chk("rst_pready_b", 32'(ready_b),  32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    xfer(0, 10'h010, 32'h0,        4'h0, 32'h0,        1'b0, 0);
    xfer(1, 10'h020, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 0);
    xfer(1, 10'h020, 32'h000000AA, 4'h1, 32'h0,        1'b0, 0);
    xfer(0, 10'h020, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 0);
    xfer(1, 10'h00C, 32'h11111111, 4'hF, 32'h0,        1'b1, 0);
    xfer(1, 10'h022, 32'h11111111, 4'hF, 32'h0,        1'b1, 0);
    xfer(1, 10'h3FF, 32'h11111111, 4'hF, 32'h0,        1'b1, 0);
    xfer(1, 10'h020, 32'h22222222, 4'h0, 32'h0,        1'b0, 0);
    xfer(0, 10'h020, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 0);
    xfer(0, 10'h00C, 32'h0,        4'h0, 32'h0,        1'b1, 0);
    xfer(1, 10'h3FC, 32'h87654321, 4'hF, 32'h0,        1'b0, 0);
    xfer(0, 10'h3FC, 32'h0,        4'h0, 32'h87654321, 1'b0, 0);
    idle(2);
    chk("prot_none", 32'(prot_seen), 32'd0);

    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 10'h020;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    idle(2);
    chk("prot_no_setup", 32'(prot_seen), 32'd1);

    xfer(1, 10'h050, 32'h12345678, 4'hF, 32'h0, 1'b0, 1);
    idle(2);
    chk("prot_addr_change", 32'(prot_seen), 32'd2);
    xfer(0, 10'h050, 32'h0, 4'h0, 32'h12345678, 1'b0, 0);
    xfer(0, 10'h060, 32'h0, 4'h0, 32'h0,        1'b0, 0);
    xfer(0, 10'h020, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 0);

    xfer(1, 10'h030, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h030;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1;
    idle(3);
    xfer(0, 10'h030, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 0);
    chk("prot_abort", 32'(prot_seen), 32'd2);

    xfer(0, 10'h020, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 2);
    idle(2);
    chk("prot_resetup", 32'(prot_seen), 32'd3);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h040;
    pwdata = 32'h00000055; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_pready", 32'(ready_a), 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_pready",  32'(ready_a),  32'd0);
    chk("mid_rst_prdata",  rdata_a,       32'd0);
    chk("mid_rst_pslverr", 32'(slverr_a), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    xfer(0, 10'h040, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    xfer(0, 10'h020, 32'h0, 4'h0, 32'h0, 1'b0, 0);
    xfer(0, 10'h3FC, 32'h0, 4'h0, 32'h0, 1'b0, 0);

    dut_b = 1'b1;
    @(posedge clk); #1;
    xfer(1, 10'h020, 32'hCAFEF00D, 4'hF, 32'h0,        1'b0, 0);
    xfer(0, 10'h020, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0);
    xfer(1, 10'h024, 32'h01020304, 4'hC, 32'h0,        1'b0, 0);
    xfer(0, 10'h024, 32'h0,        4'h0, 32'h01020000, 1'b0, 0);
    xfer(0, 10'h3FE, 32'h0,        4'h0, 32'h0,        1'b1, 0);
    idle(3);
    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("prot_final_b", 32'(prot_seen), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
